// File: rtl/controlador_motores_pkg.sv
// rtl/controlador_motores_pkg.sv - shared state encoding and mode constants for the motor sequencer
package controlador_motores_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M1    = 3'd1,
        PAUSA = 3'd2,
        M2    = 3'd3,
        AMBOS = 3'd4
    } estado_t;

    localparam logic MODO_SECUENCIAL = 1'b0;
    localparam logic MODO_SIMULTANEO = 1'b1;

endpackage

// File: rtl/controlador_motores_temporizador.sv
// rtl/controlador_motores_temporizador.sv - loadable down-counter that times each motor phase
//
// Ports:
//   CLK       rising-edge clock
//   REINICIO  asynchronous active-low reset, clears the count
//   carga     load valor on the next edge (has priority over counting)
//   valor     value to load
//   fin       high while the count is zero
module temporizador #(
    parameter int ANCHO_CNT = 8
) (
    input  logic                 CLK,
    input  logic                 REINICIO,
    input  logic                 carga,
    input  logic [ANCHO_CNT-1:0] valor,
    output logic                 fin
);

    logic [ANCHO_CNT-1:0] cuenta;

    // Counting stops at zero, so the counter rests at 0 while the sequencer idles.
    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (cuenta != '0) begin
            cuenta <= cuenta - 1'b1;
        end
    end

    assign fin = (cuenta == '0);

endmodule

// File: rtl/controlador_motores.sv
// rtl/controlador_motores.sv - two-motor sequencer, sequential or simultaneous runs started by an ARRANQUE edge
//
// Ports:
//   CLK       rising-edge clock
//   REINICIO  asynchronous active-low reset; outputs drop immediately
//   ARRANQUE  start request, rising-edge detected
//   MODO      0 = sequential (M1, pause, M2), 1 = simultaneous; sampled at start
//   MOTOR1    motor 1 enable
//   MOTOR2    motor 2 enable
//   OCUPADO   high while a run is in progress
//
// Optional feature REPETICION_EN: when defined, ARRANQUE high on the last
// cycle of a run chains straight into a new run (mode sampled afresh)
// without passing through IDLE.
module controlador_motores
    import controlador_motores_pkg::*;
#(
    parameter int T_ON      = 8,
    parameter int T_PAUSA   = 2,
    parameter int ANCHO_CNT = 8
) (
    input  logic CLK,
    input  logic REINICIO,
    input  logic ARRANQUE,
    input  logic MODO,
    output logic MOTOR1,
    output logic MOTOR2,
    output logic OCUPADO
);

    localparam logic [ANCHO_CNT-1:0] CARGA_ON    = ANCHO_CNT'(T_ON - 1);
    localparam logic [ANCHO_CNT-1:0] CARGA_PAUSA = ANCHO_CNT'(T_PAUSA - 1);

    estado_t              estado, estado_sig;
    logic                 arranque_ant;
    logic                 modo_reg;
    logic                 lanza;
    logic                 carga;
    logic [ANCHO_CNT-1:0] valor;
    logic                 fin;

    temporizador #(
        .ANCHO_CNT(ANCHO_CNT)
    ) u_temporizador (
        .CLK      (CLK),
        .REINICIO (REINICIO),
        .carga    (carga),
        .valor    (valor),
        .fin      (fin)
    );

    // History resets to 1 so a start input held high through reset is not
    // mistaken for a fresh edge.
    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO) begin
            estado       <= IDLE;
            arranque_ant <= 1'b1;
            modo_reg     <= MODO_SECUENCIAL;
        end else begin
            estado       <= estado_sig;
            arranque_ant <= ARRANQUE;
            if (lanza) begin
                modo_reg <= MODO;
            end
        end
    end

    always_comb begin
        estado_sig = estado;
        lanza      = 1'b0;
        carga      = 1'b0;
        valor      = '0;
        case (estado)
            IDLE: begin
                if (ARRANQUE && !arranque_ant) begin
                    lanza      = 1'b1;
                    carga      = 1'b1;
                    valor      = CARGA_ON;
                    estado_sig = (MODO == MODO_SIMULTANEO) ? AMBOS : M1;
                end
            end
            M1: begin
                if (fin) begin
                    carga      = 1'b1;
                    valor      = CARGA_PAUSA;
                    estado_sig = PAUSA;
                end
            end
            PAUSA: begin
                if (fin) begin
                    carga      = 1'b1;
                    valor      = CARGA_ON;
                    estado_sig = M2;
                end
            end
            M2, AMBOS: begin
                if (fin) begin
`ifdef REPETICION_EN
                    if (ARRANQUE) begin
                        lanza      = 1'b1;
                        carga      = 1'b1;
                        valor      = CARGA_ON;
                        estado_sig = (MODO == MODO_SIMULTANEO) ? AMBOS : M1;
                    end else begin
                        estado_sig = IDLE;
                    end
`else
                    estado_sig = IDLE;
`endif
                end
            end
            default: estado_sig = IDLE;
        endcase
    end

    // Moore decode only; AMBOS is additionally qualified by the latched mode.
    assign MOTOR1  = (estado == M1) || (estado == AMBOS && modo_reg == MODO_SIMULTANEO);
    assign MOTOR2  = (estado == M2) || (estado == AMBOS && modo_reg == MODO_SIMULTANEO);
    assign OCUPADO = (estado != IDLE);

endmodule

// File: tb/tb_controlador_motores.sv
// tb/tb_controlador_motores.sv - self-checking bench for controlador_motores
module tb_controlador_motores;

    localparam int T_ON    = 8;
    localparam int T_PAUSA = 2;

    logic CLK;
    logic REINICIO;
    logic ARRANQUE;
    logic MODO;
    logic MOTOR1;
    logic MOTOR2;
    logic OCUPADO;

    int checks   = 0;
    int failures = 0;

    // Reference: the run is a list of per-cycle {motor1, motor2, busy} values.
    logic [2:0] cur;
    logic [2:0] q[$];
    logic       prev;

    int n_m1, n_m2, n_ov, n_busy, n_both;

    controlador_motores #(
        .T_ON      (T_ON),
        .T_PAUSA   (T_PAUSA),
        .ANCHO_CNT (8)
    ) dut (
        .CLK      (CLK),
        .REINICIO (REINICIO),
        .ARRANQUE (ARRANQUE),
        .MODO     (MODO),
        .MOTOR1   (MOTOR1),
        .MOTOR2   (MOTOR2),
        .OCUPADO  (OCUPADO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic push_run(input logic modo);
        if (modo) begin
            for (int i = 0; i < T_ON; i++) q.push_back(3'b111);
        end else begin
            for (int i = 0; i < T_ON; i++) q.push_back(3'b101);
            for (int i = 0; i < T_PAUSA; i++) q.push_back(3'b001);
            for (int i = 0; i < T_ON; i++) q.push_back(3'b011);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur  = 3'b000;
        prev = 1'b1;
    endtask

    task automatic model_edge();
        logic start;
        if (!REINICIO) begin
            model_reset();
        end else begin
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                start = ARRANQUE && !prev && !cur[0];
`ifdef REPETICION_EN
                if (cur[0] && ARRANQUE) start = 1'b1;
`endif
                if (start) begin
                    push_run(MODO);
                    cur = q.pop_front();
                end else begin
                    cur = 3'b000;
                end
            end
            prev = ARRANQUE;
        end
    endtask

    task automatic check_out(input string tag);
        checks++;
        assert (MOTOR1 === cur[2]) else begin
            failures++;
            $error("FAIL %s motor1 observed=%b expected=%b", tag, MOTOR1, cur[2]);
        end
        checks++;
        assert (MOTOR2 === cur[1]) else begin
            failures++;
            $error("FAIL %s motor2 observed=%b expected=%b", tag, MOTOR2, cur[1]);
        end
        checks++;
        assert (OCUPADO === cur[0]) else begin
            failures++;
            $error("FAIL %s ocupado observed=%b expected=%b", tag, OCUPADO, cur[0]);
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_counts();
        n_m1 = 0; n_m2 = 0; n_ov = 0; n_busy = 0; n_both = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
    task automatic paso(input logic arr, input logic modo, input string tag);
        ARRANQUE = arr;
        MODO     = modo;
        @(posedge CLK);
        model_edge();
        #1;
        check_out(tag);
        if (MOTOR1 === 1'b1) n_m1++;
        if (MOTOR2 === 1'b1) n_m2++;
        if (MOTOR1 === 1'b1 && MOTOR2 === 1'b1) n_both++;
        if (OCUPADO === 1'b1) n_busy++;
    endtask

    initial begin
        REINICIO = 1'b0;
        ARRANQUE = 1'b0;
        MODO     = 1'b0;
        model_reset();

        // Reset held with ARRANQUE toggling: everything stays low.
        for (int i = 0; i < 6; i++) paso(logic'(i % 2), logic'($urandom_range(0, 1)), "reset_hold");
        REINICIO = 1'b1;
        paso(1'b0, 1'b0, "idle");
        paso(1'b0, 1'b0, "idle");

        // Sequential run.
        clear_counts();
        paso(1'b1, 1'b0, "seq");
        for (int i = 0; i < 21; i++) paso(1'b0, 1'b0, "seq");
        check_int("seq_m1_cycles", n_m1, T_ON);
        check_int("seq_m2_cycles", n_m2, T_ON);
        check_int("seq_busy_cycles", n_busy, 2 * T_ON + T_PAUSA);
        check_int("seq_overlap", n_both, 0);

        // Simultaneous run.
        clear_counts();
        paso(1'b1, 1'b1, "sim");
        for (int i = 0; i < 11; i++) paso(1'b0, 1'b1, "sim");
        check_int("sim_both_cycles", n_both, T_ON);
        check_int("sim_busy_cycles", n_busy, T_ON);

        // Mode flip and extra start pulse during M1 are ignored.
        clear_counts();
        paso(1'b1, 1'b0, "ignore");
        paso(1'b0, 1'b1, "ignore");
        paso(1'b1, 1'b1, "ignore");
        paso(1'b0, 1'b1, "ignore");
        for (int i = 0; i < 24; i++) paso(1'b0, 1'b1, "ignore");
        check_int("ignore_busy_cycles", n_busy, 2 * T_ON + T_PAUSA);
        check_int("ignore_overlap", n_both, 0);

        // Reset mid-M2 between edges with ARRANQUE held high.
        paso(1'b1, 1'b0, "abort_run");
        for (int i = 0; i < 13; i++) paso(1'b1, 1'b0, "abort_run");
        check_int("abort_in_m2", int'(MOTOR2), 1);
        #2;
        REINICIO = 1'b0;
        #1;
        model_reset();
        check_out("abort_immediate");
        paso(1'b1, 1'b0, "abort_hold");
        paso(1'b1, 1'b0, "abort_hold");
        #2;
        REINICIO = 1'b1;
        clear_counts();
        for (int i = 0; i < 5; i++) paso(1'b1, 1'b0, "after_release");
        check_int("no_restart_held", n_busy, 0);
        paso(1'b0, 1'b0, "after_release");
        paso(1'b1, 1'b0, "restart");
        for (int i = 0; i < 20; i++) paso(1'b0, 1'b0, "restart");

        // ARRANQUE held high across a whole run.
        clear_counts();
        paso(1'b1, 1'b0, "held");
        for (int i = 0; i < 24; i++) paso(1'b1, 1'b0, "held");
`ifdef REPETICION_EN
        check_int("held_busy_cycles", n_busy, 25);
`else
        check_int("held_busy_cycles", n_busy, 2 * T_ON + T_PAUSA);
`endif
        for (int i = 0; i < 25; i++) paso(1'b0, 1'b0, "drain");

        // Random start/mode activity against the reference.
        for (int i = 0; i < 400; i++) begin
            logic a;
            a = ($urandom_range(0, 3) == 0) ? ~ARRANQUE : ARRANQUE;
            paso(a, logic'($urandom_range(0, 1)), "random");
        end
        for (int i = 0; i < 25; i++) paso(1'b0, 1'b0, "final_drain");
        check_int("final_idle", int'(OCUPADO), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_motores.md
Name: controlador_motores

Overview:
Motor sequencer that receives CLK, REINICIO, ARRANQUE and MODO from the bench and produces MOTOR1 and MOTOR2.
- A rising edge on ARRANQUE starts one run.
- MODO selects a sequential run (motor 1, pause, motor 2) or a simultaneous run (both motors together).
- Timing comes from a single down-counter.
- Top-level DUT instantiated next to the tester in the quiz testbench.

Parameters:
- T_ON, 8: cycles each motor phase is active (1 to 2^ANCHO_CNT-1).
- T_PAUSA, 2: idle cycles between MOTOR1 and MOTOR2 in sequential mode (1 to 2^ANCHO_CNT-1).
- ANCHO_CNT, 8: width of the phase counter.

Ports:
- CLK  input  1  system clock, rising-edge.
- REINICIO  input  1  asynchronous, active-low reset.
- ARRANQUE  input  1  start request, edge-detected.
- MODO  input  1  0 = sequential, 1 = simultaneous; sampled at start.
- MOTOR1  output  1  motor 1 enable.
- MOTOR2  output  1  motor 2 enable.
- OCUPADO  output  1  high while a run is in progress.

Behaviour:
- Clocking and reset: one clock (CLK). Reset is asynchronous and active-low on REINICIO.
- Reset values:
  - state = IDLE, counter = 0, registered MODO = 0.
  - ARRANQUE history register = 1, so an input held high through reset does not start a run.
  - MOTOR1 = MOTOR2 = OCUPADO = 0, forced immediately without waiting for a clock edge.
- Start condition: ARRANQUE = 1 at a rising CLK edge while the history register = 0, with state = IDLE.
- States and transitions:
  - IDLE: all outputs 0. On start, latch MODO; go to M1 if MODO = 0, else AMBOS; load counter with T_ON-1.
  - M1: MOTOR1 = 1. At counter = 0, go to PAUSA and load T_PAUSA-1.
  - PAUSA: motors 0. At counter = 0, go to M2 and load T_ON-1.
  - M2: MOTOR2 = 1. At counter = 0, go to IDLE.
  - AMBOS: MOTOR1 = MOTOR2 = 1. At counter = 0, go to IDLE.
  - Counter decrements every cycle in any non-IDLE state.
- Outputs: Moore outputs decoded from the state register; no combinational path from any input to any output.
- Latency: start sampled at edge k, so the motor output rises after edge k.
  - Each motor is high for exactly T_ON cycles.
  - PAUSA lasts exactly T_PAUSA cycles.
- OCUPADO duration:
  - Sequential run: 2*T_ON + T_PAUSA cycles.
  - Simultaneous run: T_ON cycles.
- Sequential mode never drives MOTOR1 and MOTOR2 high in the same cycle.
- MODO changes during a run: ignored; the latched value governs the whole run.
- ARRANQUE edges while OCUPADO = 1: ignored, not queued.
- Return to IDLE: a new rising edge is required; a level held high does not restart (unless REPETICION_EN).
- Reset mid-run: immediate abort to IDLE, outputs 0. After reset release, the history register = 1 blocks a restart until ARRANQUE has gone low and then high again.

Optional Feature:
- Macro: REPETICION_EN.
- Defined: on the last cycle of M2 or AMBOS, if ARRANQUE = 1, the next state is M1/AMBOS chosen by a freshly sampled MODO, with no IDLE cycle. OCUPADO stays high continuously.
- Undefined: always return to IDLE; each run needs a new rising edge.

Decomposition:
- Package controlador_motores_pkg holds:
  - state typedef: IDLE, M1, PAUSA, M2, AMBOS (3-bit encoding).
  - constants MODO_SECUENCIAL = 0 and MODO_SIMULTANEO = 1.
- Sub-module temporizador: loadable ANCHO_CNT-bit down-counter with inputs carga and valor, and output fin (counter == 0). It uses the same CLK and REINICIO.

Test Plan (T_ON = 8, T_PAUSA = 2):
1. REINICIO = 0 with CLK running, ARRANQUE toggling -> MOTOR1 = MOTOR2 = OCUPADO = 0 throughout.
2. MODO = 0, ARRANQUE 0->1 at edge k:
   - MOTOR1 high for cycles k+1..k+8.
   - Both low for k+9..k+10.
   - MOTOR2 high for k+11..k+18.
   - OCUPADO high for 18 cycles; motors never overlap.
3. MODO = 1, ARRANQUE rising -> MOTOR1 and MOTOR2 both high for exactly 8 cycles, then IDLE.
4. Sequential run with MODO flipped to 1 and a second ARRANQUE pulse during M1 -> run completes unchanged (18 cycles) and no second run follows.
5. REINICIO pulled low mid-M2, between clock edges, with ARRANQUE held high:
   - Outputs drop immediately on the REINICIO falling edge.
   - After release, no run starts until ARRANQUE goes 0 then 1.
6. REPETICION_EN defined, ARRANQUE held high, MODO = 0 -> the cycle after the last M2 cycle shows MOTOR1 = 1 and OCUPADO never drops. Without the macro -> returns to IDLE and stays there.
